// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Handshake: a byte moves on a rising edge where byte_valid and byte_ready
// are both high; the source holds byte_data stable while byte_valid is high
// and ready is low. The write port has no back-pressure: the memory takes
// wr_data at wr_addr on every cycle wr_en is high.
interface imem_loader_if #(
  parameter int AW = 4,
  parameter int DW = 16
);
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  // Environment side: byte source plus instruction memory.
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  // Loader side.
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Serial program loader: assembles high/low byte pairs into instruction
// words, writes them to addresses 0..N_WORDS-1, then checks a trailing
// 16-bit checksum against the modulo-2^16 sum of the words.
module imem_loader #(
  parameter int N_WORDS = 15,
  parameter int AW      = 4,
  parameter int DW      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  imem_loader_if.slave       bus,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    CK_HI = 3'd4,
    CK_LO = 3'd5,
    FIN   = 3'd6
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_sum;
  logic [7:0]    r_hi;
  logic [7:0]    r_ck_hi;
  logic [DW-1:0] r_ck;
  logic          w_xfer;

  // byte_ready is a registered copy of "next state accepts bytes".
  assign w_xfer      = bus.byte_valid & bus.byte_ready;
  assign o_dbg_state = r_state;

  // Session FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_sum          <= '0;
      r_hi           <= '0;
      r_ck_hi        <= '0;
      r_ck           <= '0;
      bus.byte_ready <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done      <= 1'b0;
      bus.wr_en <= 1'b0;
      if (abort && r_state != IDLE) begin
        // Abort wins over any byte offered this cycle; that byte is dropped.
        r_state        <= IDLE;
        bus.byte_ready <= 1'b0;
        busy           <= 1'b0;
        err            <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_cnt          <= '0;
              r_sum          <= '0;
              err            <= 1'b0;
              busy           <= 1'b1;
              bus.byte_ready <= 1'b1;
              r_state        <= HI;
            end
          end
          HI: begin
            if (w_xfer) begin
              r_hi    <= bus.byte_data;
              r_state <= LO;
            end
          end
          LO: begin
            if (w_xfer) begin
              bus.wr_data    <= {r_hi, bus.byte_data};
              bus.wr_addr    <= r_cnt;
              bus.wr_en      <= 1'b1;
              bus.byte_ready <= 1'b0;
              r_state        <= WRITE;
            end
          end
          WRITE: begin
            // wr_en is high during this state; fold the word into the sum.
            r_sum          <= r_sum + bus.wr_data;
            bus.byte_ready <= 1'b1;
            if (r_cnt == AW'(N_WORDS - 1)) begin
              r_state <= CK_HI;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= HI;
            end
          end
          CK_HI: begin
            if (w_xfer) begin
              r_ck_hi <= bus.byte_data;
              r_state <= CK_LO;
            end
          end
          CK_LO: begin
            if (w_xfer) begin
              r_ck           <= {r_ck_hi, bus.byte_data};
              bus.byte_ready <= 1'b0;
              r_state        <= FIN;
            end
          end
          FIN: begin
            done    <= 1'b1;
            err     <= (r_ck != r_sum);
            busy    <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            r_state        <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter N_WORDS, default 15, number of 16-bit instruction words loaded per session (addresses 0..N_WORDS-1).
REQ-002 SHALL have parameter AW, default 4, width of the instruction memory write address.
REQ-003 SHALL have parameter DW, default 16, width of one instruction word.
REQ-004 SHALL provide: clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide: start  input  1  begin a load session, sampled only in IDLE.
REQ-007 SHALL provide: abort  input  1  cancel the session in progress.
REQ-008 SHALL provide: byte_valid  input  1  byte_data holds a valid byte.
REQ-009 SHALL provide: byte_data  input  8  serial program byte, high byte of each word first.
REQ-010 SHALL provide: byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 SHALL provide: wr_en  output  1  instruction memory write strobe.
REQ-012 SHALL provide: wr_addr  output  AW  instruction memory write address.
REQ-013 SHALL provide: wr_data  output  DW  instruction word to write.
REQ-014 SHALL provide: busy  output  1  session in progress; processor fetch is held off while high.
REQ-015 SHALL provide: done  output  1  one-cycle pulse at end of a completed session.
REQ-016 SHALL provide: err  output  1  checksum mismatch or abort; held until next accepted start.

Function
REQ-017 SHALL implement states IDLE, HI, LO, WRITE, CK_HI, CK_LO, FIN.
REQ-018 SHALL register all outputs; byte_ready is high only in HI, LO, CK_HI and CK_LO.
REQ-019 SHALL transfer a byte only on a cycle with byte_valid=1 and byte_ready=1; otherwise the state is held.
REQ-020 IDLE: start=1 SHALL clear the word counter, the running sum and err, set busy, and go to HI.
REQ-021 HI: on transfer, SHALL capture the byte as word[15:8] and go to LO.
REQ-022 LO: on transfer, SHALL form word = {hi, byte}, drive it on wr_data, and go to WRITE.
REQ-023 WRITE: SHALL assert wr_en for exactly one cycle, with wr_addr = word counter and wr_data stable.
REQ-024 WRITE: SHALL add the word to the running sum, modulo 2^16.
REQ-025 WRITE: SHALL go to CK_HI if counter = N_WORDS-1; otherwise it SHALL increment the counter and go to HI.
REQ-026 CK_HI and CK_LO SHALL receive a 16-bit checksum, high byte first, and SHALL NOT write memory.
REQ-027 After CK_LO, SHALL go to FIN; FIN SHALL pulse done for one cycle, set err if checksum != sum, clear busy, and go to IDLE.
REQ-028 Minimum session length SHALL be 3*N_WORDS + 3 cycles after start, i.e. 48 for N_WORDS=15.
REQ-029 abort=1 in any non-IDLE state SHALL go to IDLE next cycle with no wr_en and no done, set err=1, and clear busy.
REQ-030 abort SHALL take priority over a simultaneous byte transfer; that byte is dropped.
REQ-031 abort in IDLE SHALL have no effect.
REQ-032 start while busy SHALL be ignored.
REQ-033 wr_addr SHALL never exceed N_WORDS-1; the counter SHALL NOT wrap within a session.
REQ-034 wr_en and byte_ready SHALL never be high in the same cycle.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, counter=0, sum=0 and all outputs to 0, irrespective of clk.
REQ-036 Reset mid-session SHALL discard the partial word; words already written are not undone.
REQ-037 After rst_n deasserts, the first start SHALL be honoured on the next rising edge.

Verification
REQ-038 Full load: start, then bytes for words 0x0001..0x000F and checksum 0x0078 with byte_valid held high -> 15 wr_en pulses at addr 0..14 with matching data, done at cycle 48, err=0.
REQ-039 Bad checksum: same words, checksum 0x0079 -> 15 writes, done pulse, err=1 held through IDLE until the next start.
REQ-040 Backpressure gaps: byte_valid low 2 cycles between every byte -> identical writes and data, done later, no duplicate or missing writes.
REQ-041 Abort in LO of word 5 -> no 6th write, busy=0 next cycle, err=1, done=0; a subsequent start clears err.
REQ-042 Async reset asserted between clock edges during WRITE of word 3 -> outputs 0 without waiting for a clk edge, state IDLE, a restart writes from addr 0.
REQ-043 start pulsed while busy, plus abort pulsed in IDLE -> no state change and no err.
